regfile_mp: RTL

- Parametrised successor to the single-write, dual-read CPU register file.
- Configurable data width, register count, and number of read and write ports.
- Optional write-to-read bypass; optional hardwired zero register.
- Built-in dump sequencer streams every register over a valid/ready channel for the testbench and debug monitor.
- Sits in the decode stage of the datapath; the dump port feeds the trace logger.

---
 rtl/regfile_mp.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write bypass and hardwired zero register,
// plus a valid/ready dump sequencer that streams every register in index order.
module regfile_mp #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] Read_Register,
  output logic [NUM_RD*DATA_W-1:0] Read_Data,
  input  logic [NUM_WR-1:0]        Reg_Write,
  input  logic [NUM_WR*ADDR_W-1:0] Write_Register,
  input  logic [NUM_WR*DATA_W-1:0] Write_Data,
  input  logic                     Dump_Start,
  output logic                     Dump_Valid,
  input  logic                     Dump_Ready,
  output logic [ADDR_W-1:0]        Dump_Index,
  output logic [DATA_W-1:0]        Dump_Data,
  output logic                     Dump_Busy,
  output logic                     Dump_Done
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] index_reg, index_next;

  genvar gi;

  // One storage word per register; later write ports override earlier ones.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_word
        logic [DATA_W-1:0] value_reg, value_next;

        always_comb begin
          value_next = value_reg;
          for (int j = 0; j < NUM_WR; j++) begin
            if (Reg_Write[j] && Write_Register[j*ADDR_W +: ADDR_W] == ADDR_W'(gi))
              value_next = Write_Data[j*DATA_W +: DATA_W];
          end
        end

        always_ff @(posedge Clock or posedge Reset) begin
          if (Reset)
            value_reg <= (INIT_INDEX != 0) ? DATA_W'(gi) : '0;
          else
            value_reg <= value_next;
        end

        assign regs[gi] = value_reg;
      end
    end
  endgenerate

  // Combinational read ports; the zero register overrides any bypass hit.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = Read_Register[gi*ADDR_W +: ADDR_W];

      always_comb begin
        data = regs[addr];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (Reg_Write[j] && Write_Register[j*ADDR_W +: ADDR_W] == addr)
              data = Write_Data[j*DATA_W +: DATA_W];
          end
        end
        if (ZERO_REG != 0 && addr == '0)
          data = '0;
      end

      assign Read_Data[gi*DATA_W +: DATA_W] = data;
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    case (state_reg)
      IDLE: begin
        if (Dump_Start) begin
          state_next = STREAM;
          index_next = '0;
        end
      end
      STREAM: begin
        if (Dump_Ready) begin
          if (index_reg == LAST_INDEX)
            state_next = DONE;
          else
            index_next = index_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        index_next = '0;
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  // Dump data is the live register word, so a write to the presented index shows up next cycle.
  assign Dump_Valid = (state_reg == STREAM);
  assign Dump_Busy  = (state_reg != IDLE);
  assign Dump_Done  = (state_reg == DONE);
  assign Dump_Index = index_reg;
  assign Dump_Data  = Dump_Valid ? regs[index_reg] : '0;

endmodule
